// File: rtl/vga_pkg.sv
// Shared VGA-side types and defaults: controller state encoding, platform
// geometry defaults and a small magnitude helper for the multiplier.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_PEND,
    ST_COMMIT
  } state_t;

  localparam int DEF_BASE_RADIUS = 130;
  localparam int DEF_CENTER_X    = 463;
  localparam int DEF_CENTER_Y    = 275;
  localparam int MULT_BITS       = 10;

  function automatic logic [9:0] abs10(input logic [9:0] v);
    return v[9] ? (~v + 10'd1) : v;
  endfunction

endpackage

// File: rtl/seq_mult10.sv
// Iterative shift-add multiplier: 10-bit signed operands, one multiplier bit
// per cycle, 20-bit signed product held stable once the run completes.
module seq_mult10
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [9:0] op_a,
  input  logic signed [9:0] op_b,
  output logic              done,
  output logic [19:0]       product
);

  logic [19:0] mcand;
  logic [19:0] acc;
  logic [9:0]  mplier;
  logic [3:0]  count;
  logic        neg;

  // Magnitudes are multiplied; the sign is reapplied on the way out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      mcand  <= {10'b0, abs10(op_a)};
      mplier <= abs10(op_b);
      acc    <= '0;
      count  <= 4'(MULT_BITS);
      neg    <= op_a[9] ^ op_b[9];
    end else if (count != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - 4'd1;
    end
  end

  // High during the final iteration cycle; product is final after that edge.
  assign done    = (count == 4'd1);
  assign product = neg ? (~acc + 20'd1) : acc;

endmodule

// File: rtl/frame_update_ctrl.sv
// Frame-synchronous ball parameter update: captures position offsets, squares
// the radius, and commits only at vertical blanking.
// Optional drop counter enabled by FRAME_UPDATE_DROP_CNT_EN.
module frame_update_ctrl
  import vga_pkg::*;
#(
  parameter int BASE_RADIUS = DEF_BASE_RADIUS,
  parameter int CENTER_X    = DEF_CENTER_X,
  parameter int CENTER_Y    = DEF_CENTER_Y
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [7:0]  upd_pos_x,
  input  logic [7:0]  upd_pos_y,
  input  logic        frame_start,
  output logic [15:0] center_x,
  output logic [15:0] center_y,
  output logic [32:0] radius_sq,
  output logic        commit_pulse,
  output logic        busy
`ifdef FRAME_UPDATE_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  state_t state, state_nx;

  logic              accept;
  logic              mult_done;
  logic [19:0]       mult_product;
  logic [15:0]       sx;
  logic [15:0]       sy;
  logic signed [9:0] r_in;
  logic [15:0]       cx_q;
  logic [15:0]       cy_q;

  assign sx     = {{8{upd_pos_x[7]}}, upd_pos_x};
  assign sy     = {{8{upd_pos_y[7]}}, upd_pos_y};
  assign r_in   = 10'(BASE_RADIUS) + {{2{upd_pos_x[7]}}, upd_pos_x};

  assign upd_ready    = (state == ST_IDLE) || ((state == ST_PEND) && !frame_start);
  assign accept       = upd_valid && upd_ready;
  assign commit_pulse = (state == ST_COMMIT);
  assign busy         = (state != ST_IDLE);

  // The multiplier loads on the accept edge, so MULT spans its 10 iterations.
  seq_mult10 u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .op_a    (r_in),
    .op_b    (r_in),
    .done    (mult_done),
    .product (mult_product)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_MULT;
      ST_MULT:   if (mult_done) state_nx = ST_PEND;
      ST_PEND: begin
        if (frame_start)  state_nx = ST_COMMIT;
        else if (accept)  state_nx = ST_MULT;
      end
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs load on the PEND->COMMIT edge so they are valid during COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cx_q      <= 16'(CENTER_X);
      cy_q      <= 16'(CENTER_Y);
      center_x  <= 16'(CENTER_X);
      center_y  <= 16'(CENTER_Y);
      radius_sq <= 33'(BASE_RADIUS * BASE_RADIUS);
    end else begin
      state <= state_nx;
      if (accept) begin
        cx_q <= 16'(CENTER_X) + sx;
        cy_q <= 16'(CENTER_Y) + sy;
      end
      if ((state == ST_PEND) && frame_start) begin
        center_x  <= cx_q;
        center_y  <= cy_q;
        radius_sq <= {13'b0, mult_product};
      end
    end
  end

`ifdef FRAME_UPDATE_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_count <= '0;
    else if ((state == ST_PEND) && accept && (drop_count != '1))
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frame_update_ctrl.sv
// Bench for frame_update_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_frame_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [7:0]  upd_pos_x = '0;
  logic [7:0]  upd_pos_y = '0;
  logic        frame_start = 1'b0;
  logic [15:0] center_x;
  logic [15:0] center_y;
  logic [32:0] radius_sq;
  logic        commit_pulse;
  logic        busy;
`ifdef FRAME_UPDATE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;

  frame_update_ctrl #(.BASE_RADIUS(130), .CENTER_X(463), .CENTER_Y(275)) dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_pos_x    (upd_pos_x),
    .upd_pos_y    (upd_pos_y),
    .frame_start  (frame_start),
    .center_x     (center_x),
    .center_y     (center_y),
    .radius_sq    (radius_sq),
    .commit_pulse (commit_pulse),
    .busy         (busy)
`ifdef FRAME_UPDATE_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a countdown for the multiply, a pending flag, and the
  // committed values computed with plain arithmetic.
  int  m_wait = 0;
  bit  m_pend = 0;
  bit  m_commit = 0;
  int  p_cx = 463, p_cy = 275, p_r = 130;
  longint e_cx = 463, e_cy = 275, e_rsq = 16900;
  int  m_drops = 0;

  function automatic bit m_idle();
    return (m_wait == 0) && !m_pend && !m_commit;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      m_wait = 0; m_pend = 0; m_commit = 0;
      e_cx = 463; e_cy = 275; e_rsq = 16900; m_drops = 0;
    end else begin
      acc = upd_valid && (m_idle() || (m_pend && !frame_start));
      if (m_commit) m_commit = 0;
      else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_pend = 1;
      end else if (m_pend && frame_start) begin
        m_pend = 0; m_commit = 1;
        e_cx = p_cx; e_cy = p_cy; e_rsq = longint'(p_r) * longint'(p_r);
      end
      if (acc) begin
        if (m_pend && m_drops < 65535) m_drops++;
        m_pend = 0;
        m_wait = 10;
        p_cx = 463 + int'($signed(upd_pos_x));
        p_cy = 275 + int'($signed(upd_pos_y));
        p_r  = 130 + int'($signed(upd_pos_x));
      end
    end
  end

  always @(negedge clk) begin
    if (commit_pulse === 1'b1) dut_pulses++;
    check("upd_ready", longint'(upd_ready), longint'(m_idle() || (m_pend && !frame_start)));
    check("busy", longint'(busy), longint'(!m_idle()));
    check("commit_pulse", longint'(commit_pulse), longint'(m_commit));
    check("center_x", longint'(center_x), e_cx);
    check("center_y", longint'(center_y), e_cy);
    check("radius_sq", longint'(radius_sq), e_rsq);
`ifdef FRAME_UPDATE_DROP_CNT_EN
    check("drop_count", longint'(drop_count), longint'(m_drops));
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] px, input logic [7:0] py);
    upd_pos_x = px; upd_pos_y = py; upd_valid = 1'b1;
    tick(1);
    upd_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    tick(3);
    check("rst_center_x", longint'(center_x), 463);
    check("rst_center_y", longint'(center_y), 275);
    check("rst_radius_sq", longint'(radius_sq), 16900);
    check("rst_commit_pulse", longint'(commit_pulse), 0);
    check("rst_upd_ready", longint'(upd_ready), 1);
    rst = 1'b0;
    tick(2);

    // Basic update, frame_start 20 cycles after acceptance
    p0 = dut_pulses;
    offer(8'h0A, 8'hFB);
    tick(19);
    pulse_fs();
    check("c1_pulse", longint'(commit_pulse), 1);
    check("c1_center_x", longint'(center_x), 473);
    check("c1_center_y", longint'(center_y), 270);
    check("c1_radius_sq", longint'(radius_sq), 19600);
    tick(3);
    check("c1_pulse_count", longint'(dut_pulses - p0), 1);

    // frame_start during MULT is ignored
    p0 = dut_pulses;
    offer(8'hF6, 8'h14);
    tick(4);
    pulse_fs();
    tick(10);
    check("c2_no_commit", longint'(dut_pulses - p0), 0);
    check("c2_hold_x", longint'(center_x), 473);
    pulse_fs();
    check("c2_center_x", longint'(center_x), 453);
    check("c2_center_y", longint'(center_y), 295);
    check("c2_radius_sq", longint'(radius_sq), 14400);
    tick(2);

    // Overwrite while pending: only the second update commits
    p0 = dut_pulses;
    offer(8'h05, 8'h00);
    tick(11);
    check("c3_pend_ready", longint'(upd_ready), 1);
    offer(8'h80, 8'h7F);
    tick(11);
    pulse_fs();
    check("c3_center_x", longint'(center_x), 335);
    check("c3_center_y", longint'(center_y), 402);
    check("c3_radius_sq", longint'(radius_sq), 4);
`ifdef FRAME_UPDATE_DROP_CNT_EN
    check("c3_drop_count", longint'(drop_count), 1);
`endif
    tick(2);
    check("c3_pulse_count", longint'(dut_pulses - p0), 1);

    // upd_valid and frame_start together in PEND: commit wins
    offer(8'h7F, 8'h00);
    tick(11);
    upd_valid = 1'b1; frame_start = 1'b1;
    #1;
    check("c4_ready_low", longint'(upd_ready), 0);
    tick(1);
    frame_start = 1'b0;
    check("c4_center_x", longint'(center_x), 590);
    check("c4_radius_sq", longint'(radius_sq), 66049);
    check("c4_commit_ready", longint'(upd_ready), 0);
    tick(1);
    check("c4_idle_ready", longint'(upd_ready), 1);
    tick(1);
    upd_valid = 1'b0;
    check("c4_accepted", longint'(busy), 1);
    tick(11);
    pulse_fs();
    tick(2);

    // Reset in the middle of MULT aborts without commit
    p0 = dut_pulses;
    offer(8'h20, 8'h10);
    tick(4);
    rst = 1'b1;
    tick(2);
    check("c5_center_x", longint'(center_x), 463);
    check("c5_center_y", longint'(center_y), 275);
    check("c5_radius_sq", longint'(radius_sq), 16900);
    check("c5_busy", longint'(busy), 0);
    rst = 1'b0;
    tick(20);
    check("c5_no_commit", longint'(dut_pulses - p0), 0);
    check("c5_hold_x", longint'(center_x), 463);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      upd_valid   = ($urandom_range(0, 2) == 0);
      upd_pos_x   = 8'($urandom);
      upd_pos_y   = 8'($urandom);
      frame_start = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 1499) == 0);
      tick(1);
    end
    rst = 1'b0; upd_valid = 1'b0; frame_start = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_update_ctrl.md
FRAME_UPDATE_CTRL -- requirements
Module: frame_update_ctrl

Interface
REQ-001 SHALL have parameter BASE_RADIUS, default 130, meaning the platform radius in pixels at pos_x = 0.
REQ-002 SHALL have parameter CENTER_X, default 463, meaning the platform centre column in raw h_count units.
REQ-003 SHALL have parameter CENTER_Y, default 275, meaning the platform centre row in raw v_count units.
REQ-004 SHALL have port clk, input, 1, the single clock (25 MHz pixel clock domain).
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port upd_valid, input, 1, meaning a new position update is offered.
REQ-007 SHALL have port upd_ready, output, 1, meaning the update is accepted this cycle.
REQ-008 SHALL have port upd_pos_x, input, 8, the signed two's-complement X offset.
REQ-009 SHALL have port upd_pos_y, input, 8, the signed two's-complement Y offset.
REQ-010 SHALL have port frame_start, input, 1, a one-cycle pulse at the start of vertical blanking.
REQ-011 SHALL have port center_x, output, 16, the committed ball centre column.
REQ-012 SHALL have port center_y, output, 16, the committed ball centre row.
REQ-013 SHALL have port radius_sq, output, 33, the committed squared radius.
REQ-014 SHALL have port commit_pulse, output, 1, high for one cycle when new values are committed.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, MULT, PEND and COMMIT.
REQ-017 SHALL define upd_ready = (state==IDLE) or (state==PEND and not frame_start).
REQ-018 SHALL, on upd_valid&&upd_ready, capture cx = CENTER_X + sext(pos_x), cy = CENTER_Y + sext(pos_y), and r = BASE_RADIUS + sext(pos_x) as a 10-bit signed value, then enter MULT.
REQ-019 SHALL compute r*r in MULT with an iterative shift-add multiplier, one bit per cycle, for exactly 10 cycles, then enter PEND.
REQ-020 SHALL, in PEND on frame_start, enter COMMIT; COMMIT SHALL load center_x, center_y and radius_sq, assert commit_pulse, and return to IDLE on the next cycle.
REQ-021 SHALL update outputs only in COMMIT, so the displayed parameters never change mid-frame.
REQ-022 SHALL, on an accepted update while in PEND, discard the pending result, recapture the new values, and restart MULT.
REQ-023 SHALL ignore frame_start in IDLE and MULT; the result commits on the first frame_start seen in PEND.
REQ-024 SHALL hold upd_ready low in MULT and COMMIT; an offered update simply waits.
REQ-025 SHALL give a latency from acceptance to PEND of 11 cycles; outputs change in the cycle after the qualifying frame_start.
REQ-026 SHALL treat the radius as signed, with r in the range 2..257, and radius_sq as unsigned.

Reset
REQ-027 SHALL, while rst is high, hold state IDLE, center_x=CENTER_X, center_y=CENTER_Y, radius_sq=BASE_RADIUS^2, commit_pulse=0, busy=0, upd_ready=1.
REQ-028 SHALL make an assertion of rst during MULT or PEND abort the operation with no commit.

Configuration
REQ-029 SHALL, with FRAME_UPDATE_DROP_CNT_EN defined, provide output drop_count[15:0], reset to 0, incremented on each REQ-022 overwrite and saturating at 0xFFFF.
REQ-030 SHALL, without FRAME_UPDATE_DROP_CNT_EN defined, omit the drop_count port and the counter logic.

Structure
REQ-031 SHALL place the state enum and the default constants 130, 463 and 275 in the shared package vga_pkg.
REQ-032 SHALL implement the multiplier as the sub-module seq_mult10, with start/done handshake, a 10-bit signed input and a 20-bit output.

Verification
REQ-033 SHALL cover: reset with no stimulus -> center 463/275, radius_sq 16900, commit_pulse 0.
REQ-034 SHALL cover: pos_x=0x0A, pos_y=0xFB accepted, frame_start at +20 -> center 473/270, radius_sq 19600, one commit_pulse.
REQ-035 SHALL cover: frame_start 5 cycles after accept -> no commit; the next frame_start commits.
REQ-036 SHALL cover: a second update in PEND -> only the second commits, and drop_count becomes 1 when the macro is defined.
REQ-037 SHALL cover: upd_valid and frame_start in the same PEND cycle -> commit with upd_ready=0, and the update is accepted in IDLE next.
REQ-038 SHALL cover: rst pulse mid-MULT -> outputs stay at reset values and no commit_pulse occurs.
